// File: rtl/bloom_pkg.sv
// Shared types for the Bloom-filter programming sequencer.
// FSM state codes, hash source tags and the default hash-unit latency.
package bloom_pkg;

    // Default latency of the crc32 hash unit, input -> hash valid
    localparam int HASH_LAT_DEF = 2;

    // Sequencer states
    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_WRITE = 2'd3;

    // Origin of the data presented to the hash unit
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_SRCH = 2'd1,
        TAG_PAT  = 2'd2
    } src_tag_e;

endpackage

// File: rtl/bloom_src_tag_pipe.sv
// Source-tag delay line that tracks what the hash unit is working on.
// Its output lines up with hash_val_i of the shared hash unit.
module bloom_src_tag_pipe
    import bloom_pkg::*;
#(
    parameter int HASH_LAT = HASH_LAT_DEF
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  src_tag_e tag_i,
    output src_tag_e tag_o
);

    src_tag_e pipe_q [HASH_LAT];
    src_tag_e pipe_d [HASH_LAT];

    // Shift the new tag in at the head, everything else moves one slot
    always_comb begin
        pipe_d[0] = tag_i;
        for (int i = 1; i < HASH_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Tag storage; reset flushes every slot to NONE
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < HASH_LAT; i++) begin
                pipe_q[i] <= TAG_NONE;
            end
        end else begin
            for (int i = 0; i < HASH_LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign tag_o = pipe_q[HASH_LAT-1];

endmodule

// File: rtl/bloom_prog_ctrl.sv
// Bloom-filter sequencer: shares the hash unit between search and programming.
// Optional BLOOM_PROG_CNT_EN adds a saturating inserted-pattern counter (pat_cnt_o).
module bloom_prog_ctrl
    import bloom_pkg::*;
#(
    parameter int BF_N       = 4,
    parameter int MAX_S      = 32,
    parameter int HASH_CNT   = 10,
    parameter int HASH_WIDTH = 12,
    parameter int HASH_LAT   = HASH_LAT_DEF,
    parameter int CNT_W      = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 clear_req_i,
    input  logic [BF_N-1:0][7:0]                 pat_data_i,
    input  logic                                 pat_val_i,
    output logic                                 pat_ready_o,
    input  logic [MAX_S-1:0][7:0]                srch_data_i,
    input  logic [MAX_S-1:0]                     srch_val_i,
    output logic [MAX_S-1:0][7:0]                hu_data_o,
    output logic [MAX_S-1:0]                     hu_val_o,
    input  logic [HASH_CNT-1:0][HASH_WIDTH-1:0]  hash_i,
    input  logic                                 hash_val_i,
    output logic                                 srch_en_o,
    output logic                                 bf_wr_en_o,
    output logic [HASH_CNT-1:0][HASH_WIDTH-1:0]  bf_wr_addr_o,
    output logic                                 bf_wr_data_o,
    output logic                                 busy_o,
    output logic                                 err_o
`ifdef BLOOM_PROG_CNT_EN
    ,
    output logic [CNT_W-1:0]                     pat_cnt_o
`endif
);

    localparam int WCNT_W = $clog2(HASH_LAT + 1);
    localparam logic [HASH_WIDTH-1:0] ADDR_MAX = '1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(HASH_LAT);
    localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);

    logic [1:0]                            state_q, state_d;
    logic [HASH_WIDTH-1:0]                 cnt_q, cnt_d;
    logic [WCNT_W-1:0]                     wcnt_q, wcnt_d;
    logic [HASH_CNT-1:0][HASH_WIDTH-1:0]   hash_q, hash_d;
    logic                                  hv_ok_q, hv_ok_d;
    logic                                  err_q, err_d;
    logic                                  clr_pend_q, clr_pend_d;

    logic     accept;
    logic     clr_entry;
    src_tag_e tag_in;
    src_tag_e tag_out;

    bloom_src_tag_pipe #(
        .HASH_LAT (HASH_LAT)
    ) u_tag_pipe (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    // Pattern handshake: only in IDLE with no clear asked for or queued
    always_comb begin
        pat_ready_o = (state_q == ST_IDLE) & ~clear_req_i & ~clr_pend_q;
        accept      = pat_val_i & pat_ready_o;
    end

    // Hash-unit input mux: search pass-through, or the pattern window right-aligned to the top lanes
    always_comb begin
        hu_data_o = '0;
        hu_val_o  = '0;
        tag_in    = TAG_NONE;
        if (state_q == ST_IDLE) begin
            if (accept) begin
                for (int k = 0; k < BF_N; k++) begin
                    hu_data_o[MAX_S-1-k] = pat_data_i[k];
                    hu_val_o[MAX_S-1-k]  = 1'b1;
                end
                tag_in = TAG_PAT;
            end else begin
                hu_data_o = srch_data_i;
                hu_val_o  = srch_val_i;
                tag_in    = TAG_SRCH;
            end
        end
    end

    // Sequencer next-state: clear sweep, accept, wait for hashes, write
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wcnt_d     = wcnt_q;
        hash_d     = hash_q;
        hv_ok_d    = hv_ok_q;
        err_d      = err_q;
        clr_pend_d = clr_pend_q;
        unique case (state_q)
            ST_CLEAR: begin
                clr_pend_d = 1'b0;
                if (clear_req_i) begin
                    cnt_d = '0;
                end else if (cnt_q == ADDR_MAX) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (clear_req_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else if (accept) begin
                    state_d = ST_WAIT;
                    wcnt_d  = WCNT_ONE;
                    hv_ok_d = 1'b0;
                end
            end
            ST_WAIT: begin
                clr_pend_d = clr_pend_q | clear_req_i;
                if (wcnt_q == WCNT_LAST) begin
                    state_d = ST_WRITE;
                    hv_ok_d = hash_val_i;
                    if (hash_val_i) begin
                        hash_d = hash_i;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            ST_WRITE: begin
                hv_ok_d = 1'b0;
                if (clr_pend_q | clear_req_i) begin
                    state_d    = ST_CLEAR;
                    cnt_d      = '0;
                    clr_pend_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
        clr_entry = (state_d == ST_CLEAR) & (state_q != ST_CLEAR);
        if (clr_entry) begin
            err_d = 1'b0;
        end
    end

    // Bit-array write port: zero sweep in CLEAR, set captured hashes in WRITE
    always_comb begin
        bf_wr_en_o   = 1'b0;
        bf_wr_data_o = 1'b0;
        bf_wr_addr_o = '0;
        if (state_q == ST_CLEAR) begin
            bf_wr_en_o = ~rst_i;
            for (int i = 0; i < HASH_CNT; i++) begin
                bf_wr_addr_o[i] = cnt_q;
            end
        end else if (state_q == ST_WRITE) begin
            bf_wr_en_o   = hv_ok_q & ~rst_i;
            bf_wr_data_o = 1'b1;
            bf_wr_addr_o = hash_q;
        end
    end

    // Status outputs; lookups only when the returning hash came from search data
    always_comb begin
        busy_o    = (state_q != ST_IDLE);
        err_o     = err_q;
        srch_en_o = hash_val_i & (tag_out == TAG_SRCH);
    end

    // Sequencer state registers; reset restarts the clear sweep
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            wcnt_q     <= '0;
            hash_q     <= '0;
            hv_ok_q    <= 1'b0;
            err_q      <= 1'b0;
            clr_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wcnt_q     <= wcnt_d;
            hash_q     <= hash_d;
            hv_ok_q    <= hv_ok_d;
            err_q      <= err_d;
            clr_pend_q <= clr_pend_d;
        end
    end

`ifdef BLOOM_PROG_CNT_EN
    logic [CNT_W-1:0] pcnt_q, pcnt_d;

    // Inserted-pattern count: saturating, restarted whenever a clear begins
    always_comb begin
        pcnt_d = pcnt_q;
        if (clr_entry) begin
            pcnt_d = '0;
        end else if ((state_q == ST_WRITE) && hv_ok_q && (pcnt_q != '1)) begin
            pcnt_d = pcnt_q + 1'b1;
        end
    end

    // Pattern counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    assign pat_cnt_o = pcnt_q;
`endif

endmodule

// File: tb/tb_bloom_prog_ctrl.sv
// Self-checking bench for bloom_prog_ctrl with a behavioural hash unit.
// Table vectors, hand sequences and a randomized timeline reference model.
module tb_bloom_prog_ctrl;
    import bloom_pkg::*;

    localparam int BF_N = 4;
    localparam int MAX_S = 32;
    localparam int HC = 10;
    localparam int HW = 12;
    localparam int HL = 2;
    localparam int CNT_W = 16;
    localparam int NRND = 400;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     clear_req;
    logic [BF_N-1:0][7:0]     pat_data;
    logic                     pat_val;
    logic                     pat_ready;
    logic [MAX_S-1:0][7:0]    srch_data;
    logic [MAX_S-1:0]         srch_val;
    logic [MAX_S-1:0][7:0]    hu_data;
    logic [MAX_S-1:0]         hu_val;
    logic [HC-1:0][HW-1:0]    hash;
    logic                     hash_val;
    logic                     srch_en;
    logic                     bf_wr_en;
    logic [HC-1:0][HW-1:0]    bf_wr_addr;
    logic                     bf_wr_data;
    logic                     busy;
    logic                     err;
`ifdef BLOOM_PROG_CNT_EN
    logic [CNT_W-1:0]         pat_cnt;
`endif

    int errs = 0;
    int checks = 0;
    logic suppress = 1'b0;

    bloom_prog_ctrl #(
        .BF_N(BF_N), .MAX_S(MAX_S), .HASH_CNT(HC),
        .HASH_WIDTH(HW), .HASH_LAT(HL), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_i(rst), .clear_req_i(clear_req),
        .pat_data_i(pat_data), .pat_val_i(pat_val), .pat_ready_o(pat_ready),
        .srch_data_i(srch_data), .srch_val_i(srch_val),
        .hu_data_o(hu_data), .hu_val_o(hu_val),
        .hash_i(hash), .hash_val_i(hash_val), .srch_en_o(srch_en),
        .bf_wr_en_o(bf_wr_en), .bf_wr_addr_o(bf_wr_addr),
        .bf_wr_data_o(bf_wr_data), .busy_o(busy), .err_o(err)
`ifdef BLOOM_PROG_CNT_EN
        , .pat_cnt_o(pat_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [HW-1:0] hfun(input logic [31:0] w, input int i);
        logic [31:0] a;
        a = 32'h811C9DC5 ^ 32'(i);
        for (int j = 3; j >= 0; j--) begin
            a = (a ^ {24'h0, w[j*8+:8]}) * 32'h01000193;
        end
        return a[11:0] ^ a[23:12];
    endfunction

    function automatic logic [HC-1:0][HW-1:0] exp_addrs(input logic [31:0] top);
        logic [HC-1:0][HW-1:0] r;
        for (int f = 0; f < HC; f++) r[f] = hfun(top, f);
        return r;
    endfunction

    function automatic logic [HC-1:0][HW-1:0] exp_clear(input int a);
        logic [HC-1:0][HW-1:0] r;
        for (int f = 0; f < HC; f++) r[f] = HW'(a);
        return r;
    endfunction

    // pattern byte 0 is the first symbol, so it lands in the highest lane
    function automatic logic [31:0] sym_order(input logic [31:0] p);
        return {p[7:0], p[15:8], p[23:16], p[31:24]};
    endfunction

    // behavioural hash unit, HL cycles latency, hashing the top 4 lanes
    logic [1:0]  hvp = 2'b00;
    logic [31:0] hdp [2];
    always @(posedge clk) begin
        hvp[0] <= |hu_val;
        hvp[1] <= hvp[0];
        hdp[0] <= hu_data[MAX_S-1 -: 4];
        hdp[1] <= hdp[0];
    end
    always_comb begin
        hash_val = hvp[1] & ~suppress;
        for (int f = 0; f < HC; f++) hash[f] = hfun(hdp[1], f);
    end

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        pat_val = 1'b0;
        pat_data = '0;
        clear_req = 1'b0;
        srch_val = '0;
        srch_data = '0;
    endtask

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    // call while sampling the first clear cycle (address `first`)
    task automatic clear_sweep(input string nm, input int first);
        int bad = 0;
        for (int i = first; i < 4096; i++) begin
            if (i != first) begin
                @(negedge clk); #1;
            end
            if (!(bf_wr_en === 1'b1 && bf_wr_data === 1'b0 &&
                  bf_wr_addr === exp_clear(i) && hu_val === '0))
                bad++;
        end
        chk(nm, 256'(bad), 256'(0));
        @(negedge clk); #1;
        chk({nm, "_done"}, 256'(busy), 256'(0));
    endtask

    // one pattern through accept, wait, write and back to ready
    task automatic do_pat(input string nm, input logic [31:0] pat,
                          input logic [31:0] top);
        @(negedge clk);
        pat_val = 1'b1;
        pat_data = pat;
        srch_val = '1;
        srch_data = rnd256();
        #1;
        chk({nm, "_ready"}, 256'(pat_ready), 256'(1));
        chk({nm, "_hutop"}, 256'(hu_data[MAX_S-1 -: 4]), 256'(top));
        chk({nm, "_hurest"}, 256'(hu_data[MAX_S-5:0]), 256'(0));
        chk({nm, "_huval"}, 256'(hu_val), 256'(32'hF000_0000));
        @(negedge clk); idle_in(); #1;
        chk({nm, "_t1"}, 256'({busy, bf_wr_en, pat_ready}), 256'(3'b100));
        @(negedge clk); #1;
        chk({nm, "_t2"}, 256'({hash_val, srch_en, bf_wr_en}), 256'(3'b100));
        @(negedge clk); #1;
        chk({nm, "_wr"}, 256'({bf_wr_en, bf_wr_data}), 256'(2'b11));
        chk({nm, "_addr"}, 256'(bf_wr_addr), 256'(exp_addrs(top)));
        @(negedge clk); #1;
        chk({nm, "_t4"}, 256'({pat_ready, bf_wr_en}), 256'(2'b10));
    endtask

    typedef struct {
        logic [31:0] pat;
        logic [31:0] top;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] top;
    } wr_t;

    initial begin
        vec_t tbl [4];
        logic [31:0] held [3];
        wr_t wq [$];
        bit srch_hit [NRND+4];
        int next_free;
        int k;
        int bad_rdy, bad_hv, bad_wr, bad_se;
        logic [31:0] p;
        logic [255:0] sd;

        tbl[0] = '{32'h64636261, 32'h61626364};
        tbl[1] = '{32'h00000000, 32'h00000000};
        tbl[2] = '{32'hFF0000FF, 32'hFF0000FF};
        tbl[3] = '{32'h0A0B0C0D, 32'h0D0C0B0A};

        // reset state
        rst = 1'b1;
        idle_in();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 256'(busy), 256'(1));
        chk("rst_outs", 256'({bf_wr_en, bf_wr_data, pat_ready, err, srch_en}),
            256'(0));
        chk("rst_hu", 256'({hu_val, hu_data}), 256'(0));

        // initial full clear
        @(negedge clk); rst = 1'b0; #1;
        clear_sweep("init_clear", 0);

        // table-driven single patterns
        for (int t = 0; t < 4; t++)
            do_pat($sformatf("tbl%0d", t), tbl[t].pat, tbl[t].top);

        // held pat_val: accepts at rel 0,4,8, writes at 3,7,11
        for (int i = 0; i < 3; i++) held[i] = $urandom;
        k = 0;
        for (int rel = 0; rel < 12; rel++) begin
            @(negedge clk);
            pat_val = (k < 3);
            pat_data = (k < 3) ? held[k] : 32'h0;
            #1;
            chk($sformatf("held_rdy%0d", rel), 256'(pat_ready),
                256'((rel % 4) == 0));
            chk($sformatf("held_wr%0d", rel), 256'(bf_wr_en),
                256'((rel % 4) == 3));
            if ((rel % 4) == 3)
                chk($sformatf("held_addr%0d", rel), 256'(bf_wr_addr),
                    256'(exp_addrs(sym_order(held[rel/4]))));
            if (pat_ready && pat_val) k++;
        end

        // randomized traffic against the timeline model
        next_free = 0;
        bad_rdy = 0; bad_hv = 0; bad_wr = 0; bad_se = 0;
        for (int n = 0; n < NRND + 4; n++) begin
            logic e_rdy, acc, e_wr, e_se;
            logic [MAX_S-1:0] e_hv;
            logic [HC-1:0][HW-1:0] e_addr;
            @(negedge clk);
            if (n < NRND) begin
                pat_val = ($urandom_range(0, 2) == 0);
                pat_data = $urandom;
                srch_val = $urandom_range(0, 1) ? $urandom : '0;
                srch_data = rnd256();
            end else begin
                idle_in();
            end
            #1;
            e_rdy = (n >= next_free);
            acc = e_rdy && pat_val;
            srch_hit[n] = e_rdy && !pat_val && (|srch_val);
            e_hv = acc ? 32'hF000_0000 : (e_rdy ? srch_val : '0);
            if (acc) begin
                wq.push_back('{n + HL + 1, sym_order(pat_data)});
                next_free = n + HL + 2;
            end
            e_wr = (wq.size() > 0) && (wq[0].due == n);
            e_addr = e_wr ? exp_addrs(wq[0].top) : '0;
            e_se = (n >= HL) && srch_hit[n-HL];
            if (pat_ready !== e_rdy) bad_rdy++;
            if (hu_val !== e_hv) bad_hv++;
            if (srch_en !== e_se) bad_se++;
            if (e_wr) begin
                if (!(bf_wr_en === 1'b1 && bf_wr_data === 1'b1 &&
                      bf_wr_addr === e_addr)) bad_wr++;
                void'(wq.pop_front());
            end else if (bf_wr_en !== 1'b0) begin
                bad_wr++;
            end
        end
        chk("rnd_ready", 256'(bad_rdy), 256'(0));
        chk("rnd_huval", 256'(bad_hv), 256'(0));
        chk("rnd_srch_en", 256'(bad_se), 256'(0));
        chk("rnd_write", 256'(bad_wr), 256'(0));
        chk("rnd_drain", 256'(wq.size()), 256'(0));

        // search lookup alignment
        sd = rnd256();
        @(negedge clk); srch_val = '1; srch_data = sd; #1;
        chk("srch_hu", 256'(hu_data), sd);
        chk("srch_huval", 256'(hu_val), 256'(32'hFFFF_FFFF));
        @(negedge clk); idle_in(); #1;
        chk("srch_s1", 256'(srch_en), 256'(0));
        @(negedge clk); #1;
        chk("srch_s2", 256'({srch_en, hash_val}), 256'(2'b11));
        @(negedge clk); #1;
        chk("srch_s3", 256'(srch_en), 256'(0));

        // missing hash_val for a pattern: no write, sticky error
        p = $urandom;
        @(negedge clk); pat_val = 1'b1; pat_data = p; #1;
        chk("miss_ready", 256'(pat_ready), 256'(1));
        @(negedge clk); idle_in(); #1;
        @(negedge clk); suppress = 1'b1; #1;
        chk("miss_hv", 256'(hash_val), 256'(0));
        @(negedge clk); suppress = 1'b0; #1;
        chk("miss_nowr", 256'({bf_wr_en, err}), 256'(2'b01));
        @(negedge clk); #1;
        chk("miss_t4", 256'({pat_ready, err}), 256'(2'b11));
        do_pat("after_miss", 32'h44332211, 32'h11223344);
        chk("err_sticky", 256'(err), 256'(1));

        // clear clears err; reset at address 100 restarts the sweep
        @(negedge clk); clear_req = 1'b1; #1;
        chk("clr_rdy0", 256'(pat_ready), 256'(0));
        @(negedge clk); clear_req = 1'b0; #1;
        chk("clr_entry", 256'({busy, err, bf_wr_en}), 256'(3'b101));
        chk("clr_a0", 256'(bf_wr_addr), 256'(exp_clear(0)));
        repeat (100) @(negedge clk);
        #1;
        chk("clr_a100", 256'(bf_wr_addr), 256'(exp_clear(100)));
        @(negedge clk); rst = 1'b1; #1;
        chk("rst_mid", 256'({busy, bf_wr_en}), 256'(2'b10));
        @(negedge clk); rst = 1'b0; #1;
        clear_sweep("rst_restart", 0);

        // clear_req beats pat_val in IDLE
        @(negedge clk); clear_req = 1'b1; pat_val = 1'b1; pat_data = 32'h1; #1;
        chk("clrpat_rdy", 256'(pat_ready), 256'(0));
        @(negedge clk); idle_in(); #1;
        clear_sweep("clr_idle", 0);
        do_pat("post_clear", 32'hDDCCBBAA, 32'hAABBCCDD);

        // clear_req during WAIT: write completes, then clear; restart mid-clear
        p = $urandom;
        @(negedge clk); pat_val = 1'b1; pat_data = p; #1;
        chk("cw_ready", 256'(pat_ready), 256'(1));
        @(negedge clk); idle_in(); clear_req = 1'b1; #1;
        @(negedge clk); clear_req = 1'b0; #1;
        @(negedge clk); #1;
        chk("cw_wr", 256'({bf_wr_en, bf_wr_data}), 256'(2'b11));
        chk("cw_addr", 256'(bf_wr_addr), 256'(exp_addrs(sym_order(p))));
        @(negedge clk); #1;
        chk("cw_clear", 256'({busy, bf_wr_en, bf_wr_data, pat_ready}),
            256'(4'b1100));
        chk("cw_a0", 256'(bf_wr_addr), 256'(exp_clear(0)));
        repeat (50) @(negedge clk);
        clear_req = 1'b1;
        #1;
        chk("cw_a50", 256'(bf_wr_addr), 256'(exp_clear(50)));
        @(negedge clk); clear_req = 1'b0; #1;
        clear_sweep("cw_restart", 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
